// File: rtl/ift_mem_responder.sv
// ift_mem_responder: single-cycle-latency word memory slave with per-byte taint shadow storage
module ift_mem_responder #(
  parameter int unsigned Width       = 64,
  parameter int unsigned Depth       = 1024,
  parameter logic [63:0] BaseAddr    = 64'h80000000,
  parameter bit          StallEnable = 1'b0,
  parameter logic [15:0] LfsrSeed    = 16'hACE1
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               req_i,
  output logic               gnt_o,
  input  logic [63:0]        addr_i,
  input  logic               we_i,
  input  logic [Width-1:0]   wdata_i,
  input  logic [Width/8-1:0] strb_i,
  output logic               rvalid_o,
  output logic [Width-1:0]   rdata_o,
  output logic               err_o,
  input  logic               req_i_t0,
  input  logic [63:0]        addr_i_t0,
  input  logic               we_i_t0,
  input  logic [Width-1:0]   wdata_i_t0,
  input  logic [Width/8-1:0] strb_i_t0,
  output logic               gnt_o_t0,
  output logic               rvalid_o_t0,
  output logic [Width-1:0]   rdata_o_t0,
  output logic               err_o_t0
);
  localparam int unsigned Nb = Width / 8;
  localparam int unsigned Aw = Depth > 1 ? $clog2(Depth) : 1;
  logic [15:0]      lfsr_q, lfsr_d;
  logic             stall, accept, oor, ctl_t, rd, wr;
  logic [63:0]      off;
  logic [Aw-1:0]    idx;
  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] tnt_q [Depth];
  logic [Width-1:0] mem_d, tnt_d, rdata_d, rdata_t_d;
  logic             rvalid_q, err_q, rvalid_t_q, err_t_q;
  logic [Width-1:0] rdata_q, rdata_t_q;
  assign lfsr_d   = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
  assign stall    = StallEnable & lfsr_q[0];
  assign gnt_o    = req_i & ~stall;
  assign accept   = req_i & gnt_o;
  assign off      = addr_i - BaseAddr;
  assign oor      = (addr_i < BaseAddr) | ((off >> 3) >= 64'(Depth));
  assign idx      = off[Aw+2:3];
  assign ctl_t    = req_i_t0 | we_i_t0 | (|addr_i_t0);
  assign rd       = accept & ~we_i & ~oor;
  assign wr       = accept & we_i & ~oor;
  assign rdata_d   = rd ? mem_q[idx] : '0;
  assign rdata_t_d = rd ? (tnt_q[idx] | {Width{ctl_t}}) : '0;
  // merged write word; taint on a masked-off byte with a tainted strobe saturates to FF
  always_comb begin
    mem_d = mem_q[idx];
    tnt_d = tnt_q[idx];
    for (int b = 0; b < Nb; b++) begin
      if (strb_i[b]) begin
        mem_d[8*b +: 8] = wdata_i[8*b +: 8];
        tnt_d[8*b +: 8] = wdata_i_t0[8*b +: 8] | {8{ctl_t | strb_i_t0[b]}};
      end else if (strb_i_t0[b]) begin
        tnt_d[8*b +: 8] = 8'hFF;
      end
    end
  end
  always_ff @(posedge clk_i) begin
    if (wr) mem_q[idx] <= mem_d;
  end
  for (genvar w = 0; w < Depth; w++) begin : g_tnt
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) tnt_q[w] <= '0;
      else if (wr && idx == Aw'(w)) tnt_q[w] <= tnt_d;
    end
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lfsr_q     <= LfsrSeed;
      rvalid_q   <= 1'b0;
      err_q      <= 1'b0;
      rvalid_t_q <= 1'b0;
      err_t_q    <= 1'b0;
      rdata_q    <= '0;
      rdata_t_q  <= '0;
    end else begin
      lfsr_q     <= lfsr_d;
      rvalid_q   <= accept;
      err_q      <= accept & oor;
      rvalid_t_q <= req_i_t0 & gnt_o;
      err_t_q    <= accept & (|addr_i_t0);
      rdata_q    <= rdata_d;
      rdata_t_q  <= rdata_t_d;
    end
  end
  assign rvalid_o    = rvalid_q;
  assign err_o       = err_q;
  assign rdata_o     = rdata_q;
  assign rdata_o_t0  = rdata_t_q;
  assign rvalid_o_t0 = rvalid_t_q;
  assign err_o_t0    = err_t_q;
  assign gnt_o_t0    = req_i_t0 & rst_ni;
endmodule

// File: tb/tb_ift_mem_responder.sv
// tb_ift_mem_responder: directed checks of data/taint storage, errors, latency, reset and stalls
module tb_ift_mem_responder;
  localparam logic [63:0] B = 64'h80000000;
  logic clk = 1'b0, rst_n = 1'b1;
  logic req = 1'b0, we = 1'b0, req_s = 1'b0;
  logic [63:0] addr = '0, wdata = '0, addr_t = '0, wdata_t = '0;
  logic [7:0] strb = '0, strb_t = '0;
  logic req_t = 1'b0, we_t = 1'b0;
  logic gnt, rvalid, err, gnt_t, rvalid_t, err_t;
  logic [63:0] rdata, rdata_t;
  logic gnt_s, rvalid_s, err_s, gnt_ts, rvalid_ts, err_ts;
  logic [63:0] rdata_s, rdata_ts;
  int checks = 0, fails = 0;

  always #5 clk = ~clk;

  ift_mem_responder dut (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .gnt_o(gnt), .addr_i(addr), .we_i(we),
    .wdata_i(wdata), .strb_i(strb), .rvalid_o(rvalid), .rdata_o(rdata), .err_o(err),
    .req_i_t0(req_t), .addr_i_t0(addr_t), .we_i_t0(we_t), .wdata_i_t0(wdata_t), .strb_i_t0(strb_t),
    .gnt_o_t0(gnt_t), .rvalid_o_t0(rvalid_t), .rdata_o_t0(rdata_t), .err_o_t0(err_t)
  );

  ift_mem_responder #(.StallEnable(1'b1)) dut_s (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req_s), .gnt_o(gnt_s), .addr_i(addr), .we_i(we),
    .wdata_i(wdata), .strb_i(strb), .rvalid_o(rvalid_s), .rdata_o(rdata_s), .err_o(err_s),
    .req_i_t0(1'b0), .addr_i_t0(64'd0), .we_i_t0(1'b0), .wdata_i_t0(64'd0), .strb_i_t0(8'd0),
    .gnt_o_t0(gnt_ts), .rvalid_o_t0(rvalid_ts), .rdata_o_t0(rdata_ts), .err_o_t0(err_ts)
  );

  initial begin
    #300000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    return {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
  endfunction

  // presents one request at a negedge; returns at the next negedge, when its response is visible
  task automatic issue(input logic w, input logic [63:0] a, input logic [63:0] d, input logic [7:0] s);
    req = 1'b1; we = w; addr = a; wdata = d; strb = s;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0; we = 1'b0; strb = '0;
  endtask

  task automatic test_reset;
    #1 rst_n = 1'b0;
    req_t = 1'b1; addr_t = 64'hFF;
    @(negedge clk);
    checks++; if ({rvalid, err, rdata, rdata_t, rvalid_t, err_t, gnt_t} !== '0) begin
      fails++; $display("FAIL reset_outputs got=%0b/%0b/%h/%h/%0b/%0b/%0b exp=all zero", rvalid, err, rdata, rdata_t, rvalid_t, err_t, gnt_t);
    end
    req_t = 1'b0; addr_t = '0;
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    checks++; if (rvalid !== 1'b0) begin fails++; $display("FAIL reset_idle_rvalid got=%0b exp=0", rvalid); end
  endtask

  task automatic test_write_read;
    issue(1'b1, B + 8, 64'hAAAA_BBBB_CCCC_DDDD, 8'hFF);
    checks++; if (rvalid !== 1'b1) begin fails++; $display("FAIL wr_rvalid got=%0b exp=1", rvalid); end
    checks++; if (rdata !== 64'd0) begin fails++; $display("FAIL wr_rdata got=%h exp=0", rdata); end
    issue(1'b1, B + 8, 64'h1122334455667788, 8'h0F);
    checks++; if ({rvalid, err} !== 2'b10) begin fails++; $display("FAIL wr2_rvalid_err got=%b exp=10", {rvalid, err}); end
    issue(1'b0, B + 8, '0, '0);
    checks++; if (rvalid !== 1'b1) begin fails++; $display("FAIL rd_rvalid got=%0b exp=1", rvalid); end
    checks++; if (rdata !== 64'hAAAA_BBBB_5566_7788) begin fails++; $display("FAIL rd_strb_merge got=%h exp=aaaabbbb55667788", rdata); end
    checks++; if (rdata_t !== 64'd0) begin fails++; $display("FAIL rd_clean_taint got=%h exp=0", rdata_t); end
    @(negedge clk);
    checks++; if ({rvalid, rdata, err} !== '0) begin fails++; $display("FAIL idle_hold got=%0b/%h/%0b exp=0/0/0", rvalid, rdata, err); end
  endtask

  task automatic test_taint;
    wdata_t = 64'h00FF;
    issue(1'b1, B, 64'h0123456789ABCDEF, 8'hFF);
    wdata_t = '0;
    checks++; if (rdata_t !== 64'd0) begin fails++; $display("FAIL wr_rdata_t got=%h exp=0", rdata_t); end
    issue(1'b0, B, '0, '0);
    checks++; if (rdata !== 64'h0123456789ABCDEF) begin fails++; $display("FAIL taint_rd_data got=%h exp=0123456789abcdef", rdata); end
    checks++; if (rdata_t !== 64'h00FF) begin fails++; $display("FAIL taint_rd got=%h exp=00ff", rdata_t); end
    addr_t = 64'h20;
    issue(1'b0, B, '0, '0);
    addr_t = '0;
    checks++; if (rdata_t !== '1) begin fails++; $display("FAIL taint_addr_rd got=%h exp=all ones", rdata_t); end
    checks++; if ({err, err_t} !== 2'b01) begin fails++; $display("FAIL taint_addr_err got=%b exp=01", {err, err_t}); end
    issue(1'b1, B + 16, 64'h5555555555555555, 8'hFF);
    strb_t = 8'h02;
    issue(1'b1, B + 16, 64'h00000000000000AA, 8'h01);
    strb_t = '0;
    issue(1'b0, B + 16, '0, '0);
    checks++; if (rdata !== 64'h55555555555555AA) begin fails++; $display("FAIL strb_t_data got=%h exp=55555555555555aa", rdata); end
    checks++; if (rdata_t !== 64'hFF00) begin fails++; $display("FAIL strb_t_taint got=%h exp=ff00", rdata_t); end
    we_t = 1'b1;
    issue(1'b1, B + 24, '0, 8'h81);
    we_t = 1'b0;
    issue(1'b0, B + 24, '0, '0);
    checks++; if (rdata_t !== 64'hFF000000000000FF) begin fails++; $display("FAIL we_t_taint got=%h exp=ff000000000000ff", rdata_t); end
    req_t = 1'b1; req = 1'b1; we = 1'b0; addr = B;
    #1;
    checks++; if ({gnt, gnt_t} !== 2'b11) begin fails++; $display("FAIL gnt_t got=%b exp=11", {gnt, gnt_t}); end
    @(posedge clk);
    @(negedge clk);
    req = 1'b0; req_t = 1'b0;
    checks++; if ({rvalid, rvalid_t} !== 2'b11) begin fails++; $display("FAIL rvalid_t got=%b exp=11", {rvalid, rvalid_t}); end
    checks++; if (rdata_t !== '1) begin fails++; $display("FAIL req_t_rd got=%h exp=all ones", rdata_t); end
    @(negedge clk);
    checks++; if ({rvalid, rvalid_t, rdata_t} !== '0) begin fails++; $display("FAIL rvalid_t_idle got=%0b/%0b/%h exp=0/0/0", rvalid, rvalid_t, rdata_t); end
  endtask

  task automatic test_oor;
    issue(1'b0, 64'h7FFFFFF8, '0, '0);
    checks++; if ({rvalid, err} !== 2'b11) begin fails++; $display("FAIL oor_low got=%b exp=11", {rvalid, err}); end
    checks++; if ({rdata, rdata_t} !== '0) begin fails++; $display("FAIL oor_low_data got=%h/%h exp=0/0", rdata, rdata_t); end
    addr_t = 64'h1;
    issue(1'b0, B + 64'd8192, '0, '0);
    addr_t = '0;
    checks++; if ({err, err_t} !== 2'b11) begin fails++; $display("FAIL oor_high got=%b exp=11", {err, err_t}); end
    checks++; if (rdata !== 64'd0) begin fails++; $display("FAIL oor_high_data got=%h exp=0", rdata); end
    issue(1'b1, B + 64'd8192, 64'hDEADBEEFDEADBEEF, 8'hFF);
    checks++; if ({rvalid, err} !== 2'b11) begin fails++; $display("FAIL oor_wr got=%b exp=11", {rvalid, err}); end
    issue(1'b0, B, '0, '0);
    checks++; if ({err, rdata} !== {1'b0, 64'h0123456789ABCDEF}) begin fails++; $display("FAIL oor_no_alias got=%0b/%h exp=0/0123456789abcdef", err, rdata); end
    issue(1'b1, B + 64'd8184, 64'hCAFEF00DCAFEF00D, 8'hFF);
    issue(1'b0, B + 64'd8191, '0, '0);
    checks++; if ({err, rdata} !== {1'b0, 64'hCAFEF00DCAFEF00D}) begin fails++; $display("FAIL last_word got=%0b/%h exp=0/cafef00dcafef00d", err, rdata); end
  endtask

  task automatic test_back_to_back;
    issue(1'b1, B + 32, 64'h0F0F0F0F0F0F0F0F, 8'hFF);
    checks++; if (rvalid !== 1'b1) begin fails++; $display("FAIL b2b_wr got=%0b exp=1", rvalid); end
    issue(1'b1, B + 32, 64'h0000000000001234, 8'h03);
    checks++; if (rvalid !== 1'b1) begin fails++; $display("FAIL b2b_wr2 got=%0b exp=1", rvalid); end
    issue(1'b0, B + 32, '0, '0);
    checks++; if ({rvalid, rdata} !== {1'b1, 64'h0F0F0F0F0F0F1234}) begin fails++; $display("FAIL raw got=%0b/%h exp=1/0f0f0f0f0f0f1234", rvalid, rdata); end
  endtask

  task automatic test_reset_drop;
    int pulses = 0;
    req = 1'b1; we = 1'b0; addr = B;
    @(posedge clk);
    #1 rst_n = 1'b0; req = 1'b0;
    @(negedge clk);
    checks++; if (rvalid !== 1'b0) begin fails++; $display("FAIL drop_in_reset got=%0b exp=0", rvalid); end
    @(negedge clk) rst_n = 1'b1;
    repeat (3) begin @(negedge clk); pulses += int'(rvalid); end
    checks++; if (pulses != 0) begin fails++; $display("FAIL drop_after_release got=%0d pulses exp=0", pulses); end
    issue(1'b0, B, '0, '0);
    checks++; if (rdata_t !== 64'd0) begin fails++; $display("FAIL taint_cleared got=%h exp=0", rdata_t); end
    checks++; if (rdata !== 64'h0123456789ABCDEF) begin fails++; $display("FAIL data_kept got=%h exp=0123456789abcdef", rdata); end
  endtask

  task automatic test_stall;
    logic [15:0] m = 16'hACE1;
    logic prev = 1'b0;
    int ng = 0, nr = 0;
    rst_n = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    we = 1'b0; addr = B; req_s = 1'b1;
    for (int i = 0; i < 40; i++) begin
      #1;
      checks++; if (gnt_s !== ~m[0]) begin fails++; $display("FAIL stall_gnt cyc=%0d got=%0b exp=%0b", i, gnt_s, ~m[0]); end
      checks++; if (rvalid_s !== prev) begin fails++; $display("FAIL stall_rvalid cyc=%0d got=%0b exp=%0b", i, rvalid_s, prev); end
      nr += int'(rvalid_s);
      prev = ~m[0];
      ng += int'(prev);
      @(posedge clk);
      m = lfsr_step(m);
      @(negedge clk);
    end
    req_s = 1'b0;
    #1 nr += int'(rvalid_s);
    @(negedge clk);
    checks++; if (rvalid_s !== 1'b0) begin fails++; $display("FAIL stall_tail got=%0b exp=0", rvalid_s); end
    checks++; if (nr != ng) begin fails++; $display("FAIL stall_count got=%0d rvalids exp=%0d", nr, ng); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_taint();
    test_oor();
    test_back_to_back();
    test_reset_drop();
    test_stall();
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule

// File: doc/ift_mem_responder.md
IFT_MEM_RESPONDER -- requirements
Module: ift_mem_responder

Interface
REQ-001 SHALL have parameter Width, default 64, data word width in bits (fixed at 64; strobe width Width/8).
REQ-002 SHALL have parameter Depth, default 1024, number of Width-bit words stored.
REQ-003 SHALL have parameter BaseAddr, default 64'h80000000, byte address mapped to word 0.
REQ-004 SHALL have parameters StallEnable (default 0) and LfsrSeed (default 16'hACE1, must be nonzero), which control pseudo-random grant stalls.
REQ-005 SHALL have the following ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset; one clock, asynchronous, active-low.
- req_i  in  1  request from initiator.
- gnt_o  out  1  request accepted this cycle.
- addr_i  in  64  byte address.
- we_i  in  1  1=write, 0=read.
- wdata_i  in  64  write data.
- strb_i  in  8  byte write enables.
- rvalid_o  out  1  response valid.
- rdata_o  out  64  read data.
- err_o  out  1  response is out-of-range error, qualified by rvalid_o.
REQ-006 SHALL have taint ports req_i_t0, addr_i_t0, we_i_t0, wdata_i_t0, strb_i_t0 (inputs, same widths as their counterparts) and gnt_o_t0, rvalid_o_t0, rdata_o_t0, err_o_t0 (outputs, same widths as their counterparts).

Function
REQ-007 SHALL define accept = req_i & gnt_o; gnt_o = req_i & ~stall, combinational.
REQ-008 SHALL assert stall = StallEnable & lfsr[0], where lfsr is a 16-bit Fibonacci LFSR (taps 16,14,13,11) that advances every cycle and resets to LfsrSeed.
REQ-009 SHALL compute idx = (addr_i - BaseAddr) >> 3 and flag out-of-range when addr_i < BaseAddr or idx >= Depth; addr_i[2:0] ignored.
REQ-010 SHALL, on an accepted in-range write, update each byte b of word idx whose strb_i[b]=1 with wdata_i byte b at the clock edge; bytes with strb_i[b]=0 are unchanged.
REQ-011 SHALL, on that write, set taint byte b = wdata_i_t0 byte b | {8{req_i_t0 | we_i_t0 | (|addr_i_t0) | strb_i_t0[b]}} for each enabled byte; where strb_i_t0[b]=1 and strb_i[b]=0, SHALL OR 8'hFF into the stored taint byte.
REQ-012 SHALL, one cycle after any accept, pulse rvalid_o=1 for exactly one cycle; response latency is fixed at 1 cycle; back-to-back accepts give back-to-back rvalid pulses.
REQ-013 SHALL, for an accepted in-range read, drive rdata_o = word idx and rdata_o_t0 = stored taint word | {64{|addr_i_t0 | req_i_t0 | we_i_t0}} on the rvalid cycle.
REQ-014 SHALL, for writes, drive rdata_o=0 and rdata_o_t0=0 on the rvalid cycle.
REQ-015 SHALL, for an out-of-range accept, perform no storage update, drive rdata_o=0, and set err_o=1 on the rvalid cycle; err_o_t0 = |addr_i_t0 registered with the request.
REQ-016 SHALL hold rdata_o, rdata_o_t0 and err_o at 0 whenever rvalid_o=0.
REQ-017 SHALL drive gnt_o_t0 = req_i_t0, and rvalid_o_t0 = registered (req_i_t0 & gnt_o).
REQ-018 SHALL serve a read and a write to the same word in consecutive cycles so that the read returns the post-write value (read-after-write without hazard).
REQ-019 SHALL raise no response when req_i=0 or stall=1; the stalled request stays pending at the initiator and is not latched.

Reset
REQ-020 SHALL, while rst_ni=0, force rvalid_o, err_o, rdata_o and all *_t0 outputs to 0 and the lfsr to LfsrSeed.
REQ-021 SHALL clear all taint storage to 0 on reset; data storage is not reset.
REQ-022 SHALL drop a response pending at reset assertion; no rvalid_o pulse follows reset release until a new accept.

Verification
REQ-023 Write 0x80000008, wdata=64'h1122334455667788, strb=8'h0F, then read the same address -> rvalid 1 cycle after each accept; readback low 32 bits = 0x55667788.
REQ-024 Write 0x80000000 with wdata_i_t0=64'h00FF, strb=8'hFF, then read with no input taint -> rdata_o_t0=64'h00FF; a read with addr_i_t0[5]=1 -> rdata_o_t0=all ones.
REQ-025 Read 0x7FFFFFF8 and 0x80000000+8*Depth -> err_o=1, rdata_o=0, storage unchanged.
REQ-026 StallEnable=1, continuous req_i -> gnt_o=0 exactly on cycles where lfsr[0]=1, one rvalid per grant, no extra pulses.
REQ-027 Assert rst_ni=0 the cycle after an accept -> no rvalid_o pulse; taint readback of any word = 0.
